// File: rtl/alu_dispatch_unit.sv
// Dispatches one RV64 integer instruction to the ALU over the trigger/idle handshake and returns the result on a valid/ready writeback port.
// Optional WAIT-state watchdog is enabled by defining ALU_DISPATCH_TIMEOUT_EN.
module alu_dispatch_unit #(
    parameter int OPERAND_WIDTH  = 64,
    parameter int OPCODE_WIDTH   = 17,
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     inst_valid,
    output logic                     inst_ready,
    input  logic [31:0]              inst_word,
    input  logic [OPERAND_WIDTH-1:0] rs1_data,
    input  logic [OPERAND_WIDTH-1:0] rs2_data,
    output logic [OPERAND_WIDTH-1:0] operand_1,
    output logic [OPERAND_WIDTH-1:0] operand_2,
    output logic [OPCODE_WIDTH-1:0]  op_code,
    output logic                     alu_trig,
    input  logic                     alu_idle,
    input  logic [OPERAND_WIDTH-1:0] alu_result,
    output logic                     wb_valid,
    input  logic                     wb_ready,
    output logic [4:0]               wb_rd,
    output logic [OPERAND_WIDTH-1:0] wb_data,
    output logic                     wb_we,
    output logic                     wb_illegal,
    output logic                     wb_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + SETTLE_CYCLES + 1) + 1;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WB    = 2'd3
    } state_e;

    state_e                   state_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [OPERAND_WIDTH-1:0] operand_1_q;
    logic [OPERAND_WIDTH-1:0] operand_2_q;
    logic [OPCODE_WIDTH-1:0]  op_code_q;
    logic                     alu_trig_q;
    logic                     wb_valid_q;
    logic [4:0]               wb_rd_q;
    logic [OPERAND_WIDTH-1:0] wb_data_q;
    logic                     wb_we_q;
    logic                     wb_illegal_q;
    logic                     wb_timeout_q;

    logic [6:0]               opcode_s;
    logic [2:0]               funct3_s;
    logic [6:0]               funct7_s;
    logic [9:0]               funct10_s;
    logic [OPERAND_WIDTH-1:0] imm_s;
    logic [OPERAND_WIDTH-1:0] shamt_s;
    logic                     accept_s;
    logic                     settled_s;
    logic                     unused_s;

    logic [OPCODE_WIDTH-1:0]  op_code_d;
    logic [OPERAND_WIDTH-1:0] operand_2_d;
    logic                     illegal_d;

    assign opcode_s  = inst_word[6:0];
    assign funct3_s  = inst_word[14:12];
    assign funct7_s  = inst_word[31:25];
    // funct7 bits 5 and 6 are swapped so SUB lands on 0x200 and MUL on 0x008.
    assign funct10_s = {funct7_s[5], funct7_s[6], funct7_s[4:0], funct3_s};
    assign imm_s     = {{(OPERAND_WIDTH-12){inst_word[31]}}, inst_word[31:20]};
    assign shamt_s   = {{(OPERAND_WIDTH-6){1'b0}}, inst_word[25:20]};
    assign unused_s  = ^inst_word[19:15];

    assign accept_s  = inst_valid && inst_ready;
    assign settled_s = (cnt_q >= CNT_W'(SETTLE_CYCLES));

    assign inst_ready = (state_q == ST_IDLE) && alu_idle;
    assign operand_1  = operand_1_q;
    assign operand_2  = operand_2_q;
    assign op_code    = op_code_q;
    assign alu_trig   = alu_trig_q;
    assign wb_valid   = wb_valid_q;
    assign wb_rd      = wb_rd_q;
    assign wb_data    = wb_data_q;
    assign wb_we      = wb_we_q;
    assign wb_illegal = wb_illegal_q;
    assign wb_timeout = wb_timeout_q;

    // Instruction decode: ALU op_code, operand_2 source and legality.
    always_comb begin
        op_code_d   = {OPCODE_WIDTH{1'b0}};
        operand_2_d = rs2_data;
        illegal_d   = 1'b1;
        case (opcode_s)
            OPC_OP: begin
                op_code_d   = {funct10_s, opcode_s};
                operand_2_d = rs2_data;
                case (funct10_s)
                    10'h000, 10'h200, 10'h001, 10'h002, 10'h003,
                    10'h004, 10'h005, 10'h006, 10'h007, 10'h008: illegal_d = 1'b0;
                    default:                                      illegal_d = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                op_code_d = {7'b0000000, funct3_s, opcode_s};
                if ((funct3_s == 3'b001) || (funct3_s == 3'b101)) begin
                    operand_2_d = shamt_s;
                    illegal_d   = (funct7_s[6:1] != 6'b000000);
                end else begin
                    operand_2_d = imm_s;
                    illegal_d   = 1'b0;
                end
            end
            default: begin
                op_code_d   = {OPCODE_WIDTH{1'b0}};
                operand_2_d = rs2_data;
                illegal_d   = 1'b1;
            end
        endcase
    end

    // Dispatch FSM with all ALU-side and writeback outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            operand_1_q  <= {OPERAND_WIDTH{1'b0}};
            operand_2_q  <= {OPERAND_WIDTH{1'b0}};
            op_code_q    <= {OPCODE_WIDTH{1'b0}};
            alu_trig_q   <= 1'b0;
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= 5'd0;
            wb_data_q    <= {OPERAND_WIDTH{1'b0}};
            wb_we_q      <= 1'b0;
            wb_illegal_q <= 1'b0;
            wb_timeout_q <= 1'b0;
        end else begin
            alu_trig_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        wb_rd_q <= inst_word[11:7];
                        if (illegal_d) begin
                            // Illegal instructions never touch the ALU.
                            state_q      <= ST_WB;
                            wb_valid_q   <= 1'b1;
                            wb_data_q    <= {OPERAND_WIDTH{1'b0}};
                            wb_we_q      <= 1'b0;
                            wb_illegal_q <= 1'b1;
                            wb_timeout_q <= 1'b0;
                        end else begin
                            state_q     <= ST_ISSUE;
                            operand_1_q <= rs1_data;
                            operand_2_q <= operand_2_d;
                            op_code_q   <= op_code_d;
                            alu_trig_q  <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_WAIT;
                    cnt_q   <= {CNT_W{1'b0}};
                end
                ST_WAIT: begin
                    if (settled_s && alu_idle) begin
                        state_q      <= ST_WB;
                        wb_valid_q   <= 1'b1;
                        wb_data_q    <= alu_result;
                        wb_we_q      <= (wb_rd_q != 5'd0);
                        wb_illegal_q <= 1'b0;
                        wb_timeout_q <= 1'b0;
                    end
`ifdef ALU_DISPATCH_TIMEOUT_EN
                    else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state_q      <= ST_WB;
                        wb_valid_q   <= 1'b1;
                        wb_data_q    <= {OPERAND_WIDTH{1'b0}};
                        wb_we_q      <= 1'b0;
                        wb_illegal_q <= 1'b0;
                        wb_timeout_q <= 1'b1;
                    end
`endif
                    else if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_WB: begin
                    if (wb_ready) begin
                        state_q    <= ST_IDLE;
                        wb_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    wb_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_dispatch_unit.sv
// Scoreboard bench for alu_dispatch_unit: directed RV64 vectors, an ALU stub and decoupled trigger/writeback monitors.
module tb_alu_dispatch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inst_valid = 1'b0;
    logic        inst_ready;
    logic [31:0] inst_word = 32'h0;
    logic [63:0] rs1_data = 64'h0;
    logic [63:0] rs2_data = 64'h0;
    logic [63:0] operand_1;
    logic [63:0] operand_2;
    logic [16:0] op_code;
    logic        alu_trig;
    logic        alu_idle = 1'b1;
    logic [63:0] alu_result = 64'h0;
    logic        wb_valid;
    logic        wb_ready = 1'b1;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        wb_we;
    logic        wb_illegal;
    logic        wb_timeout;

    always #5 clk = ~clk;

    alu_dispatch_unit dut (
        .clk(clk), .rst_n(rst_n),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_word(inst_word),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .operand_1(operand_1), .operand_2(operand_2), .op_code(op_code),
        .alu_trig(alu_trig), .alu_idle(alu_idle), .alu_result(alu_result),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_we(wb_we), .wb_illegal(wb_illegal), .wb_timeout(wb_timeout)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
        logic        we;
        logic        ill;
        logic        to;
    } wb_exp_t;

    typedef struct {
        logic [16:0] opc;
        logic [63:0] op1;
        logic [63:0] op2;
    } trig_exp_t;

    wb_exp_t   wb_q[$];
    trig_exp_t trig_q[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_trig(input logic [16:0] opc, input logic [63:0] op1, input logic [63:0] op2);
        trig_exp_t t;
        t.opc = opc; t.op1 = op1; t.op2 = op2;
        trig_q.push_back(t);
    endtask

    task automatic exp_wb(input logic [4:0] rd, input logic [63:0] data, input logic we,
                          input logic ill, input logic to);
        wb_exp_t w;
        w.rd = rd; w.data = data; w.we = we; w.ill = ill; w.to = to;
        wb_q.push_back(w);
    endtask

    // ALU stub: small reference ALU with programmable busy time
    int          stub_delay = 1;
    bit          stub_hang  = 1'b0;
    int          busy       = 0;
    logic [63:0] stub_res   = 64'h0;

    function automatic logic [63:0] alu_model(input logic [16:0] opc, input logic [63:0] a,
                                              input logic [63:0] b);
        case (opc)
            17'h00033: return a + b;
            17'h10033: return a - b;
            17'h00433: return a * b;
            17'h00013: return a + b;
            17'h00093: return a << b[5:0];
            default:   return 64'hDEAD_BEEF;
        endcase
    endfunction

    always @(posedge clk) begin
        if (alu_trig) begin
            alu_idle <= 1'b0;
            busy     <= stub_delay;
            stub_res <= alu_model(op_code, operand_1, operand_2);
        end else if (busy > 1) begin
            busy <= busy - 1;
        end else if (busy == 1 && !stub_hang) begin
            busy       <= 0;
            alu_idle   <= 1'b1;
            alu_result <= stub_res;
        end
    end

    // Trigger monitor
    logic      trig_prev = 1'b0;
    trig_exp_t te;
    always @(negedge clk) begin
        if (alu_trig) begin
            check("trig_one_cycle", {63'b0, trig_prev}, 64'h0);
            if (trig_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_trig: got op_code %h expected no trigger", op_code);
            end else begin
                te = trig_q.pop_front();
                check("op_code", {47'b0, op_code}, {47'b0, te.opc});
                check("operand_1", operand_1, te.op1);
                check("operand_2", operand_2, te.op2);
            end
        end
        trig_prev <= alu_trig;
    end

    // Writeback monitor
    wb_exp_t we_exp;
    always @(negedge clk) begin
        if (rst_n && wb_valid) begin
            if (wb_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_wb: got rd %0d data %h expected no writeback", wb_rd, wb_data);
            end else begin
                we_exp = wb_q[0];
                check("wb_rd", {59'b0, wb_rd}, {59'b0, we_exp.rd});
                check("wb_data", wb_data, we_exp.data);
                check("wb_we", {63'b0, wb_we}, {63'b0, we_exp.we});
                check("wb_illegal", {63'b0, wb_illegal}, {63'b0, we_exp.ill});
                check("wb_timeout", {63'b0, wb_timeout}, {63'b0, we_exp.to});
                if (!we_exp.to) check("idle_before_wb", {63'b0, alu_idle}, 64'h1);
                if (!wb_ready) check("stall_inst_ready", {63'b0, inst_ready}, 64'h0);
                else we_exp = wb_q.pop_front();
            end
        end
    end

    task automatic issue(input logic [31:0] iw, input logic [63:0] r1, input logic [63:0] r2);
        int n;
        @(posedge clk); #1;
        inst_valid = 1'b1; inst_word = iw; rs1_data = r1; rs2_data = r2;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!inst_ready && n < 50);
        if (!inst_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout: got inst_ready 0 expected 1 within 50 cycles");
        end
        @(posedge clk); #1;
        inst_valid = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while ((wb_q.size() != 0 || trig_q.size() != 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (wb_q.size() != 0 || trig_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d wb / %0d trig pending expected 0", wb_q.size(), trig_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wb_valid", {63'b0, wb_valid}, 64'h0);
        check("rst_alu_trig", {63'b0, alu_trig}, 64'h0);
        check("rst_op_code", {47'b0, op_code}, 64'h0);
        check("rst_operand_1", operand_1, 64'h0);
        check("rst_wb_data", wb_data, 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", {63'b0, inst_ready}, 64'h1);

        // ADD x3,x1,x2
        exp_trig(17'h00033, 64'd5, 64'd7); exp_wb(5'd3, 64'd12, 1'b1, 1'b0, 1'b0);
        issue(32'h002081B3, 64'd5, 64'd7); drain(40);

        // SUB x4,x1,x2
        exp_trig(17'h10033, 64'd10, 64'd3); exp_wb(5'd4, 64'd7, 1'b1, 1'b0, 1'b0);
        issue(32'h40208233, 64'd10, 64'd3); drain(40);

        // ADDI x5,x1,-1
        exp_trig(17'h00013, 64'd10, 64'hFFFF_FFFF_FFFF_FFFF); exp_wb(5'd5, 64'd9, 1'b1, 1'b0, 1'b0);
        issue(32'hFFF08293, 64'd10, 64'd0); drain(40);

        // SLLI x6,x1,4 with a slow ALU
        stub_delay = 8;
        exp_trig(17'h00093, 64'd1, 64'd4); exp_wb(5'd6, 64'd16, 1'b1, 1'b0, 1'b0);
        issue(32'h00409313, 64'd1, 64'd0); drain(60);
        stub_delay = 1;

        // MUL x7 with writeback back-pressure
        wb_ready = 1'b0;
        exp_trig(17'h00433, 64'd6, 64'd7); exp_wb(5'd7, 64'd42, 1'b1, 1'b0, 1'b0);
        issue(32'h022083B3, 64'd6, 64'd7);
        n = 0;
        while (!wb_valid && n < 40) begin @(negedge clk); n++; end
        repeat (5) @(posedge clk);
        #1 wb_ready = 1'b1;
        drain(40);

        // Latency of a single-cycle op with wb_ready high
        exp_trig(17'h00033, 64'd1, 64'd2); exp_wb(5'd3, 64'd3, 1'b1, 1'b0, 1'b0);
        issue(32'h002081B3, 64'd1, 64'd2);
        n = 0;
        do begin @(negedge clk); n++; end while (!wb_valid && n < 40);
        check("latency", 64'(n), 64'd5);
        drain(40);

        // Illegal opcode, SRAI, illegal R funct10
        exp_wb(5'd0, 64'd0, 1'b0, 1'b1, 1'b0);
        issue(32'h0000007F, 64'd1, 64'd2); drain(20);
        exp_wb(5'd8, 64'd0, 1'b0, 1'b1, 1'b0);
        issue(32'h4030D413, 64'd1, 64'd2); drain(20);
        exp_wb(5'd4, 64'd0, 1'b0, 1'b1, 1'b0);
        issue(32'h40209233, 64'd1, 64'd2); drain(20);

        // ADD x0: result delivered but not written
        exp_trig(17'h00033, 64'd5, 64'd7); exp_wb(5'd0, 64'd12, 1'b0, 1'b0, 1'b0);
        issue(32'h00208033, 64'd5, 64'd7); drain(40);

        // Reset while waiting on the ALU: no writeback, no re-trigger
        exp_trig(17'h00033, 64'd5, 64'd7);
        issue(32'h002081B3, 64'd5, 64'd7);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_wb_valid", {63'b0, wb_valid}, 64'h0);
        check("midrst_alu_trig", {63'b0, alu_trig}, 64'h0);
        check("midrst_op_code", {47'b0, op_code}, 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        drain(5);
        exp_trig(17'h10033, 64'd20, 64'd5); exp_wb(5'd9, 64'd15, 1'b1, 1'b0, 1'b0);
        issue(32'h402084B3, 64'd20, 64'd5); drain(40);

`ifdef ALU_DISPATCH_TIMEOUT_EN
        // ALU that never returns to idle
        stub_hang = 1'b1;
        exp_trig(17'h00033, 64'd5, 64'd7); exp_wb(5'd3, 64'd0, 1'b0, 1'b0, 1'b1);
        issue(32'h002081B3, 64'd5, 64'd7); drain(400);
        @(negedge clk);
        check("to_ready_low", {63'b0, inst_ready}, 64'h0);
        stub_hang = 1'b0;
        repeat (3) @(negedge clk);
        check("to_ready_back", {63'b0, inst_ready}, 64'h1);
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
